rnd_victim_sel: RTL

//  Cache replacement victim selector, downstream consumer of the 16-bit LFSR state.
//  On a request it picks one way of a set: lowest invalid unlocked way first, else a

---
 rtl/rnd_victim_sel_pkg.sv | 16 +
 rtl/rnd_victim_sel_lfsr.sv | 30 +++
 rtl/rnd_victim_sel.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rnd_victim_sel_pkg.sv
// Shared types and default sizing for the random cache-victim selector.
package rnd_victim_sel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } selState_e;

   localparam int DEF_WAYS     = 8;
   localparam int DEF_WAYS_LOG = 3;
   localparam int DEF_ID_W     = 4;
   localparam int DEF_MAX_WAIT = 15;

   localparam logic [15:0] DEF_INITVAL = 16'he45b;

endpackage

// File: rtl/rnd_victim_sel_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); OUT2 is the current state.
module LFSR16_1_16 #(
   parameter logic [15:0] INITVAL = 16'he45b
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] OUT2
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic        feedback;

   // Maximal-length taps, so any non-zero seed never reaches the all-zero lockup state.
   always_comb begin
      feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
      state_d  = {state_q[14:0], feedback};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INITVAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign OUT2 = state_q;

endmodule

// File: rtl/rnd_victim_sel.sv
// Cache victim selector: lowest free way first, else an LFSR-seeded rotating scan
// over unlocked ways; waits a bounded time for an unlock when every way is locked.
module rnd_victim_sel
   import rnd_victim_sel_pkg::*;
#(
   parameter int          WAYS     = DEF_WAYS,
   parameter int          WAYS_LOG = DEF_WAYS_LOG,
   parameter int          ID_W     = DEF_ID_W,
   parameter int          MAX_WAIT = DEF_MAX_WAIT,
   parameter logic [15:0] INITVAL  = DEF_INITVAL
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_en,
   input  logic [ID_W-1:0]     req_id,
   input  logic [WAYS-1:0]     valid_mask,
   input  logic [WAYS-1:0]     lock_mask,
   input  logic                cancel,
   output logic                busy,
   output logic                vict_en,
   output logic [WAYS_LOG-1:0] vict_way,
   output logic [ID_W-1:0]     vict_id,
   output logic                vict_inv,
   output logic                vict_fail
);

   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   selState_e           state_q, state_d;
   logic [7:0]          waitCnt_q, waitCnt_d;
   logic [WAYS-1:0]     validCap_q, validCap_d;
   logic [ID_W-1:0]     idCap_q, idCap_d;
   logic                victEn_q, victEn_d;
   logic [WAYS_LOG-1:0] victWay_q, victWay_d;
   logic [ID_W-1:0]     victId_q, victId_d;
   logic                victInv_q, victInv_d;
   logic                victFail_q, victFail_d;

   logic [15:0]         rnd;
   logic [WAYS_LOG-1:0] cand;
   logic [WAYS-1:0]     selValid;
   logic [WAYS-1:0]     freeMask;
   logic [WAYS_LOG-1:0] scanIdx;
   logic                pick;
   logic                pickInv;
   logic [WAYS_LOG-1:0] pickWay;
   logic                unusedRndBits;

   LFSR16_1_16 #(
      .INITVAL (INITVAL)
   ) uLfsr (
      .clk  (clk),
      .rst  (rst),
      .OUT2 (rnd)
   );

   assign cand          = rnd[WAYS_LOG-1:0];
   assign unusedRndBits = ^rnd[15:WAYS_LOG];

   // In IDLE the request's own valid bits are used; in WAIT the captured copy,
   // while lock bits are always live so an unlock can release a waiting request.
   always_comb begin
      selValid = (state_q == IDLE) ? valid_mask : validCap_q;
      freeMask = ~selValid & ~lock_mask;
      pick     = 1'b0;
      pickInv  = 1'b0;
      pickWay  = '0;
      scanIdx  = '0;
      if (|freeMask) begin
         pick    = 1'b1;
         pickInv = 1'b1;
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (freeMask[w]) begin
               pickWay = WAYS_LOG'(w);
            end
         end
      end else if (!(&lock_mask)) begin
         pick = 1'b1;
         // Scanning downward lets the smallest offset from cand win; the
         // WAYS_LOG-bit add wraps modulo WAYS since WAYS is a power of two.
         for (int k = WAYS - 1; k >= 0; k--) begin
            scanIdx = cand + WAYS_LOG'(k);
            if (!lock_mask[scanIdx]) begin
               pickWay = scanIdx;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      validCap_d = validCap_q;
      idCap_d    = idCap_q;
      victEn_d   = 1'b0;
      victInv_d  = 1'b0;
      victFail_d = 1'b0;
      victWay_d  = victWay_q;
      victId_d   = victId_q;
      unique case (state_q)
         IDLE: begin
            if (req_en) begin
               validCap_d = valid_mask;
               idCap_d    = req_id;
               if (pick) begin
                  victEn_d  = 1'b1;
                  victWay_d = pickWay;
                  victInv_d = pickInv;
                  victId_d  = req_id;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = 8'd0;
               end
            end
         end
         WAIT: begin
            // Cancel wins even when an unlock would have produced a pick this cycle.
            if (cancel) begin
               state_d   = IDLE;
               waitCnt_d = 8'd0;
            end else if (pick) begin
               state_d   = IDLE;
               waitCnt_d = 8'd0;
               victEn_d  = 1'b1;
               victWay_d = pickWay;
               victInv_d = pickInv;
               victId_d  = idCap_q;
            end else if (waitCnt_q == LAST_WAIT) begin
               state_d    = IDLE;
               waitCnt_d  = 8'd0;
               victEn_d   = 1'b1;
               victFail_d = 1'b1;
               victWay_d  = '0;
               victId_d   = idCap_q;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         waitCnt_q  <= 8'd0;
         validCap_q <= '0;
         idCap_q    <= '0;
         victEn_q   <= 1'b0;
         victWay_q  <= '0;
         victId_q   <= '0;
         victInv_q  <= 1'b0;
         victFail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         validCap_q <= validCap_d;
         idCap_q    <= idCap_d;
         victEn_q   <= victEn_d;
         victWay_q  <= victWay_d;
         victId_q   <= victId_d;
         victInv_q  <= victInv_d;
         victFail_q <= victFail_d;
      end
   end

   assign busy      = (state_q == WAIT);
   assign vict_en   = victEn_q;
   assign vict_way  = victWay_q;
   assign vict_id   = victId_q;
   assign vict_inv  = victInv_q;
   assign vict_fail = victFail_q;

endmodule
